// File: rtl/nios2_oci_dct_pkg.sv
// Shared state encoding and default parameter values for the DCT trace capture block.
package nios2_oci_dct_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } dct_state_t;

  localparam int DEF_SLOT_W = 2;
  localparam int DEF_SLOTS  = 15;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_DROP_W = 8;
  localparam int TS_W       = 32;

endpackage

// File: rtl/nios2_oci_dct_fifo.sv
// Capture FIFO with a registered head: an entry pushed into an empty FIFO is visible on
// out_valid/out_data right after its write edge; a push is accepted when full only alongside a pop.
module nios2_oci_dct_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             push_accepted,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [LW-1:0]    level
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ZERO = {LW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic             pop_ok;
  logic [LW-1:0]    next_level;
  logic [WIDTH-1:0] head;

  // Next occupancy, read pointer and head entry for the coming edge.
  always_comb begin
    pop_ok        = pop && out_valid;
    push_accepted = push && ((level != FULL_LVL) || pop_ok);
    next_level    = level + LW'(push_accepted) - LW'(pop_ok);
    rd_next       = pop_ok ? (rd_ptr + PTR_ONE) : rd_ptr;
    // A push that lands in an otherwise empty FIFO bypasses storage into the head register.
    if (push_accepted && (level == LW'(pop_ok))) begin
      head = din;
    end else if (next_level != LVL_ZERO) begin
      head = mem[rd_next];
    end else begin
      head = out_data;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_accepted && !clear) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers, occupancy and registered head.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= {AW{1'b0}};
      rd_ptr    <= {AW{1'b0}};
      level     <= LVL_ZERO;
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
    end else if (clear) begin
      wr_ptr    <= {AW{1'b0}};
      rd_ptr    <= {AW{1'b0}};
      level     <= LVL_ZERO;
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
    end else begin
      if (push_accepted) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_ptr    <= rd_next;
      level     <= next_level;
      out_valid <= (next_level != LVL_ZERO);
      out_data  <= head;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_capture.sv
// DCT trace buffer capture: queues completed buffers, drains them on a ready/valid port, and
// handles end-of-test flush and abort. NIOS2_OCI_DCT_TIMESTAMP_EN adds a per-entry cycle stamp.
module nios2_oci_dct_capture
  import nios2_oci_dct_pkg::*;
#(
  parameter int SLOT_W = DEF_SLOT_W,
  parameter int SLOTS  = DEF_SLOTS,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int DROP_W = DEF_DROP_W,
  localparam int BUF_W = SLOT_W * SLOTS,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [BUF_W-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]  dct_count,
  input  logic              dct_valid,
  input  logic              test_ending,
  input  logic              test_has_ended,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUF_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic [LW-1:0]     fifo_level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_count,
  output logic              flush_done,
  output logic              aborted
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  ,output logic [TS_W-1:0]  out_timestamp
`endif
);

`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  localparam int ENT_W = TS_W + BUF_W + CNT_W;
`else
  localparam int ENT_W = BUF_W + CNT_W;
`endif

  localparam logic [CNT_W-1:0]  SLOTS_CNT = CNT_W'(SLOTS);
  localparam logic [DROP_W-1:0] DROP_MAX  = {DROP_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_ONE  = DROP_W'(1'b1);
  localparam logic [LW-1:0]     LVL_ZERO  = {LW{1'b0}};

  dct_state_t       state;
  logic             valid_in;
  logic [CNT_W-1:0] sat_cnt;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_clear;
  logic             push_accepted;
  logic [ENT_W-1:0] ent_in;
  logic [ENT_W-1:0] ent_out;

`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  // Free-running cycle stamp, wraps naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts <= {TS_W{1'b0}};
    end else begin
      ts <= ts + TS_W'(1'b1);
    end
  end
`endif

  // Write qualification, count saturation and FIFO controls.
  always_comb begin
    valid_in = dct_valid && (dct_count != {CNT_W{1'b0}});
    if (dct_count > SLOTS_CNT) begin
      sat_cnt = SLOTS_CNT;
    end else begin
      sat_cnt = dct_count;
    end
    fifo_clear = test_has_ended && (state != DONE);
    fifo_push  = valid_in && (state == RUN) && !test_has_ended;
    fifo_pop   = out_ready && (state != DONE);
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    ent_in = {ts, dct_buffer, sat_cnt};
`else
    ent_in = {dct_buffer, sat_cnt};
`endif
  end

  nios2_oci_dct_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset_n       (reset_n),
    .clear         (fifo_clear),
    .push          (fifo_push),
    .din           (ent_in),
    .pop           (fifo_pop),
    .push_accepted (push_accepted),
    .out_valid     (out_valid),
    .out_data      (ent_out),
    .level         (fifo_level)
  );

  assign {out_data, out_count} = ent_out[BUF_W+CNT_W-1:0];
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  assign out_timestamp = ent_out[ENT_W-1 -: TS_W];
`endif

  // Capture state machine with sticky status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RUN;
      overflow   <= 1'b0;
      drop_count <= {DROP_W{1'b0}};
      flush_done <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (test_has_ended) begin
            state      <= DONE;
            flush_done <= 1'b1;
            if (fifo_level != LVL_ZERO) begin
              aborted <= 1'b1;
            end
          end else begin
            if (fifo_push && !push_accepted) begin
              overflow <= 1'b1;
              if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + DROP_ONE;
              end
            end
            if (test_ending) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (test_has_ended) begin
            state      <= DONE;
            flush_done <= 1'b1;
            if (fifo_level != LVL_ZERO) begin
              aborted <= 1'b1;
            end
          end else begin
            // Late buffers are counted as lost but are not an overflow.
            if (valid_in && (drop_count != DROP_MAX)) begin
              drop_count <= drop_count + DROP_ONE;
            end
            if (fifo_level == LVL_ZERO) begin
              state      <= DONE;
              flush_done <= 1'b1;
            end
          end
        end
        DONE: begin
          flush_done <= 1'b1;
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Randomized self-checking bench for nios2_oci_dct_capture against a queue-based reference model.
module tb_nios2_oci_dct_capture;

  localparam int BUF_W = 30;
  localparam int B7_W  = 14;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [BUF_W-1:0]  dct_buffer = '0;
  logic [3:0]        dct_count = '0;
  logic              dct_valid = 1'b0;
  logic              test_ending = 1'b0;
  logic              test_has_ended = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [BUF_W-1:0]  out_data;
  logic [3:0]        out_count;
  logic [4:0]        fifo_level;
  logic              overflow;
  logic [7:0]        drop_count;
  logic              flush_done;
  logic              aborted;
  logic              o7_valid;
  logic [B7_W-1:0]   o7_data;
  logic [3:0]        o7_count;
  logic [4:0]        o7_level;
  logic              o7_overflow;
  logic [7:0]        o7_drop;
  logic              o7_flush_done;
  logic              o7_aborted;
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  logic [31:0]       out_ts;
  logic [31:0]       o7_ts;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nios2_oci_dct_capture dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count),
    .flush_done(flush_done), .aborted(aborted)
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    , .out_timestamp(out_ts)
`endif
  );

  nios2_oci_dct_capture #(.SLOTS(7)) dut7 (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer[B7_W-1:0]), .dct_count(dct_count),
    .dct_valid(dct_valid), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .out_valid(o7_valid), .out_ready(out_ready), .out_data(o7_data), .out_count(o7_count),
    .fifo_level(o7_level), .overflow(o7_overflow), .drop_count(o7_drop),
    .flush_done(o7_flush_done), .aborted(o7_aborted)
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    , .out_timestamp(o7_ts)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [BUF_W-1:0] d;
    int               c;
    int               c7;
    int unsigned      ts;
  } ent_t;

  ent_t        mq[$];
  int          m_phase;   // 0 running, 1 flushing, 2 finished
  bit          m_ovf;
  bit          m_abort;
  bit          m_done;
  int          m_drops;
  int unsigned m_cyc;

  task automatic model_reset();
    mq.delete();
    m_phase = 0; m_ovf = 0; m_abort = 0; m_done = 0; m_drops = 0; m_cyc = 0;
  endtask

  // Applies the inputs currently driven, as seen at the coming rising edge.
  task automatic model_edge();
    bit   was_empty;
    bit   pop;
    bit   nz;
    ent_t e;
    was_empty = (mq.size() == 0);
    pop       = (mq.size() > 0) && out_ready && (m_phase != 2);
    nz        = dct_valid && (dct_count != 4'd0);
    if (m_phase != 2 && test_has_ended) begin
      if (!was_empty) m_abort = 1;
      mq.delete();
      m_phase = 2;
      m_done  = 1;
    end else if (m_phase == 0) begin
      if (pop) void'(mq.pop_front());
      if (nz) begin
        if (mq.size() < 16) begin
          e.d  = dct_buffer;
          e.c  = (int'(dct_count) > 15) ? 15 : int'(dct_count);
          e.c7 = (int'(dct_count) > 7) ? 7 : int'(dct_count);
          e.ts = m_cyc;
          mq.push_back(e);
        end else begin
          m_ovf = 1;
          if (m_drops < 255) m_drops++;
        end
      end
      if (test_ending) m_phase = 1;
    end else if (m_phase == 1) begin
      if (pop) void'(mq.pop_front());
      if (nz && m_drops < 255) m_drops++;
      if (was_empty) begin
        m_phase = 2;
        m_done  = 1;
      end
    end
    m_cyc++;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dct_valid = 1'b0; dct_count = 4'd0; test_ending = 1'b0; test_has_ended = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({out_valid, fifo_level, overflow, drop_count, flush_done, aborted} !== 17'd0) begin
      n_err++;
      $display("FAIL reset_status got v=%0b lvl=%0d ovf=%0b drop=%0d fd=%0b ab=%0b want all 0",
               out_valid, fifo_level, overflow, drop_count, flush_done, aborted);
    end
    n_cmp++;
    if ({out_data, out_count} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_data got %h/%0d want 0/0", out_data, out_count);
    end
  endtask

  task automatic test_single_write();
    out_ready = 1'b1;
    dct_buffer = 30'h2AAAAAAA; dct_count = 4'd4; dct_valid = 1'b1;
    step();
    dct_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 30'h2AAAAAAA || out_count !== 4'd4 || fifo_level !== 5'd1) begin
      n_err++;
      $display("FAIL single_present got v=%0b d=%h c=%0d lvl=%0d want 1 2aaaaaaa 4 1",
               out_valid, out_data, out_count, fifo_level);
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin
      n_err++;
      $display("FAIL single_pop got v=%0b lvl=%0d want 0 0", out_valid, fifo_level);
    end
  endtask

  task automatic test_count_rules();
    logic [BUF_W-1:0] b;
    out_ready = 1'b0;
    dct_buffer = 30'($urandom); dct_count = 4'd0; dct_valid = 1'b1;
    step();
    n_cmp++;
    if (fifo_level !== 5'd0 || out_valid !== 1'b0 || drop_count !== 8'd0) begin
      n_err++;
      $display("FAIL zero_count got lvl=%0d v=%0b drop=%0d want 0 0 0", fifo_level, out_valid, drop_count);
    end
    b = 30'($urandom);
    dct_buffer = b; dct_count = 4'hF;
    step();
    dct_valid = 1'b0;
    n_cmp++;
    if (out_count !== 4'd15 || out_data !== b || fifo_level !== 5'd1) begin
      n_err++;
      $display("FAIL count_sat15 got c=%0d d=%h lvl=%0d want 15 %h 1", out_count, out_data, fifo_level, b);
    end
    n_cmp++;
    if (o7_valid !== 1'b1 || o7_count !== 4'd7 || o7_data !== b[B7_W-1:0] || o7_level !== 5'd1) begin
      n_err++;
      $display("FAIL count_sat7 got v=%0b c=%0d d=%h lvl=%0d want 1 7 %h 1",
               o7_valid, o7_count, o7_data, o7_level, b[B7_W-1:0]);
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (fifo_level !== 5'd0) begin
      n_err++;
      $display("FAIL count_drain got lvl=%0d want 0", fifo_level);
    end
  endtask

  task automatic test_overflow();
    int guard;
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      dct_buffer = 30'($urandom); dct_count = 4'd1; dct_valid = 1'b1;
      step();
    end
    n_cmp++;
    if (fifo_level !== 5'd16 || overflow !== 1'b1 || drop_count !== 8'd1) begin
      n_err++;
      $display("FAIL overflow_fill got lvl=%0d ovf=%0b drop=%0d want 16 1 1", fifo_level, overflow, drop_count);
    end
    out_ready = 1'b1;
    dct_buffer = 30'($urandom);
    step();
    dct_valid = 1'b0;
    n_cmp++;
    if (fifo_level !== 5'd16 || drop_count !== 8'd1) begin
      n_err++;
      $display("FAIL full_push_pop got lvl=%0d drop=%0d want 16 1", fifo_level, drop_count);
    end
    guard = 0;
    while (mq.size() > 0 && guard < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      guard++;
      n_cmp++;
      if (out_valid !== (mq.size() > 0) || fifo_level !== 5'(mq.size()) ||
          (mq.size() > 0 && out_data !== mq[0].d)) begin
        n_err++;
        $display("FAIL drain_order got v=%0b lvl=%0d d=%h want lvl=%0d d=%h",
                 out_valid, fifo_level, out_data, mq.size(), (mq.size() > 0) ? mq[0].d : 30'd0);
      end
    end
    n_cmp++;
    if (guard >= 200) begin
      n_err++;
      $display("FAIL drain_timeout got %0d cycles want < 200", guard);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      dct_valid  = 1'($urandom_range(0, 1));
      dct_count  = 4'($urandom_range(0, 15));
      dct_buffer = 30'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
      step();
      n_cmp++;
      if (out_valid !== (mq.size() > 0) || fifo_level !== 5'(mq.size()) ||
          overflow !== m_ovf || drop_count !== 8'(m_drops) ||
          (mq.size() > 0 && (out_data !== mq[0].d || out_count !== 4'(mq[0].c)))) begin
        n_err++;
        $display("FAIL random_%0d got v=%0b lvl=%0d ovf=%0b drop=%0d d=%h c=%0d want lvl=%0d ovf=%0b drop=%0d",
                 i, out_valid, fifo_level, overflow, drop_count, out_data, out_count,
                 mq.size(), m_ovf, m_drops);
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    int guard;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dct_buffer = 30'($urandom); dct_count = 4'($urandom_range(1, 15)); dct_valid = 1'b1;
      step();
    end
    dct_buffer = 30'($urandom); test_ending = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (fifo_level !== 5'd4 || flush_done !== 1'b0) begin
      n_err++;
      $display("FAIL flush_entry got lvl=%0d fd=%0b want 4 0", fifo_level, flush_done);
    end
    out_ready = 1'b1;
    guard = 0;
    while (!m_done && guard < 20) begin
      step();
      guard++;
      n_cmp++;
      if (out_valid !== (mq.size() > 0) || fifo_level !== 5'(mq.size()) || flush_done !== m_done ||
          (mq.size() > 0 && out_data !== mq[0].d)) begin
        n_err++;
        $display("FAIL flush_drain got v=%0b lvl=%0d fd=%0b d=%h want lvl=%0d fd=%0b",
                 out_valid, fifo_level, flush_done, out_data, mq.size(), m_done);
      end
    end
    n_cmp++;
    if (guard != 5) begin
      n_err++;
      $display("FAIL flush_latency got %0d cycles want 5", guard);
    end
    dct_valid = 1'b1; dct_count = 4'd3;
    step();
    idle_inputs();
    n_cmp++;
    if (drop_count !== 8'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || flush_done !== 1'b1) begin
      n_err++;
      $display("FAIL done_ignores got drop=%0d ovf=%0b v=%0b fd=%0b want 0 0 0 1",
               drop_count, overflow, out_valid, flush_done);
    end
  endtask

  task automatic test_flush_drop();
    do_reset();
    out_ready = 1'b0;
    dct_valid = 1'b1; dct_count = 4'd2; dct_buffer = 30'($urandom); test_ending = 1'b1;
    step();
    test_ending = 1'b0; dct_count = 4'd6;
    step();
    dct_valid = 1'b0;
    n_cmp++;
    if (drop_count !== 8'(m_drops) || drop_count !== 8'd1 || overflow !== 1'b0 || fifo_level !== 5'd1) begin
      n_err++;
      $display("FAIL flush_drop got drop=%0d ovf=%0b lvl=%0d want 1 0 1", drop_count, overflow, fifo_level);
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      dct_buffer = 30'($urandom); dct_count = 4'd2; dct_valid = 1'b1;
      step();
    end
    dct_valid = 1'b0; test_has_ended = 1'b1; test_ending = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (fifo_level !== 5'd0 || aborted !== 1'b1 || out_valid !== 1'b0 || flush_done !== 1'b1) begin
      n_err++;
      $display("FAIL abort got lvl=%0d ab=%0b v=%0b fd=%0b want 0 1 0 1", fifo_level, aborted, out_valid, flush_done);
    end
    dct_valid = 1'b1; dct_count = 4'd2; out_ready = 1'b1;
    step();
    idle_inputs();
    n_cmp++;
    if (fifo_level !== 5'(mq.size()) || fifo_level !== 5'd0 || drop_count !== 8'd0) begin
      n_err++;
      $display("FAIL abort_done_idle got lvl=%0d drop=%0d want 0 0", fifo_level, drop_count);
    end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      dct_buffer = 30'($urandom); dct_count = 4'd3; dct_valid = 1'b1;
      step();
    end
    dct_valid = 1'b0; test_ending = 1'b1;
    step();
    test_ending = 1'b0; out_ready = 1'b1;
    step();
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, fifo_level, overflow, drop_count, flush_done, aborted} !== 17'd0 ||
        {out_data, out_count} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_mid_flush got v=%0b lvl=%0d d=%h fd=%0b want all 0",
               out_valid, fifo_level, out_data, flush_done);
    end
    do_reset();
    dct_buffer = 30'($urandom); dct_count = 4'd5; dct_valid = 1'b1;
    step();
    dct_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || fifo_level !== 5'd1 || out_count !== 4'd5 || out_data !== mq[0].d) begin
      n_err++;
      $display("FAIL post_reset_write got v=%0b lvl=%0d c=%0d want 1 1 5", out_valid, fifo_level, out_count);
    end
  endtask

`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  task automatic test_timestamp();
    int unsigned first;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      dct_valid = (i == 10 || i == 25); dct_count = 4'd1; dct_buffer = 30'($urandom);
      step();
    end
    dct_valid = 1'b0;
    first = out_ts;
    n_cmp++;
    if (out_ts !== mq[0].ts || out_ts !== 32'd10) begin
      n_err++;
      $display("FAIL ts_first got %0d want 10", out_ts);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_ts - first !== 32'd15 || out_ts !== mq[0].ts) begin
      n_err++;
      $display("FAIL ts_delta got %0d want 15", out_ts - first);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_count_rules();
    test_overflow();
    test_random();
    test_flush();
    test_flush_drop();
    test_abort();
    test_reset_mid_flush();
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/nios2_oci_dct_capture.md
NIOS2_OCI_DCT_CAPTURE -- requirements
Module: nios2_oci_dct_capture

Interface
REQ-001 SHALL have parameter SLOT_W, default 2, bits per trace slot.
REQ-002 SHALL have parameter SLOTS, default 15, slots per DCT buffer; BUF_W = SLOT_W*SLOTS (default 30).
REQ-003 SHALL have parameter CNT_W, default 4, width of slot count.
REQ-004 SHALL have parameter DEPTH, default 16, FIFO entries, power of two >= 2.
REQ-005 SHALL have parameter DROP_W, default 8, drop counter width.
REQ-006 SHALL have clock and reset: one clock; reset is asynchronous and active-low. Ports: clk input 1, rising-edge clock; reset_n input 1, asynchronous active-low reset.
REQ-007 SHALL have ports: dct_buffer input BUF_W, packed trace slots; dct_count input CNT_W, valid slots in buffer; dct_valid input 1, buffer-complete strobe.
REQ-008 SHALL have ports: test_ending input 1, begin end-of-test flush; test_has_ended input 1, abort and stop.
REQ-009 SHALL have ports: out_valid output 1; out_ready input 1; out_data output BUF_W; out_count output CNT_W.
REQ-010 SHALL have ports: fifo_level output $clog2(DEPTH)+1; overflow output 1, sticky; drop_count output DROP_W; flush_done output 1; aborted output 1, sticky.

Function
REQ-011 SHALL implement states RUN, FLUSH, DONE; reset state RUN.
REQ-012 SHALL, in RUN, write {dct_buffer, dct_count} into the FIFO on the same edge that samples dct_valid=1, provided dct_count != 0.
REQ-013 SHALL ignore dct_valid when dct_count == 0: no write, no drop count.
REQ-014 SHALL saturate a stored count greater than SLOTS to SLOTS.
REQ-015 SHALL present a written entry on out_valid exactly one cycle after the write edge when the FIFO was empty.
REQ-016 SHALL pop on clk edge when out_valid && out_ready; out_data/out_count SHALL remain stable while out_valid && !out_ready.
REQ-017 SHALL, when full, accept a write in the same cycle as a pop; a write while full without a pop SHALL be dropped, SHALL set overflow, and SHALL increment drop_count (saturating at all-ones).
REQ-018 SHALL, on test_ending=1 in RUN, move to FLUSH; a dct_valid sampled in that same cycle SHALL still be written.
REQ-019 SHALL, in FLUSH, accept no writes; dct_valid with nonzero count SHALL increment drop_count without setting overflow; drain continues.
REQ-020 SHALL move FLUSH->DONE the cycle after the FIFO becomes empty; flush_done=1 in DONE.
REQ-021 SHALL, on test_has_ended=1 in RUN or FLUSH, move to DONE next edge, discard FIFO contents (fifo_level=0), and set aborted if the FIFO was non-empty; test_has_ended has priority over test_ending.
REQ-022 SHALL hold out_valid=0 and ignore all inputs except reset in DONE.
REQ-023 SHALL report fifo_level as occupancy 0..DEPTH, updated on the write/pop edge.

Reset
REQ-024 SHALL asynchronously clear on reset_n=0: state=RUN, FIFO pointers, out_valid=0, out_data=0, out_count=0, fifo_level=0, overflow=0, drop_count=0, flush_done=0, aborted=0.
REQ-025 SHALL treat reset mid-FLUSH or mid-transfer as full discard; the first post-reset write SHALL behave as REQ-015.

Configuration
REQ-026 SHALL support macro NIOS2_OCI_DCT_TIMESTAMP_EN: when defined, add output out_timestamp 32 bits (reset 0) carrying a free-running 32-bit cycle counter sampled at the write edge and stored with the entry (wraps modulo 2^32); when undefined, the port and counter SHALL not exist and all other behaviour SHALL be identical.

Structure
REQ-027 SHALL place the state enum (RUN/FLUSH/DONE) and default parameter constants in shared package nios2_oci_dct_pkg.
REQ-028 SHALL implement storage as sub-module nios2_oci_dct_fifo (parametrised width/depth, registered output, simultaneous push/pop when full).

Verification
REQ-029 Single write: dct_buffer=30'h2AAAAAAA, dct_count=4, dct_valid 1 cycle, out_ready=1 -> out_valid=1 exactly one cycle later with same data, count 4; fifo_level 1->0.
REQ-030 Overflow: out_ready=0, 17 writes count=1 -> fifo_level=16, overflow=1, drop_count=1; one write+pop same cycle when full -> level stays 16, drop_count unchanged.
REQ-031 Count rules: dct_valid with dct_count=0 -> no write; dct_count=4'hF -> out_count=15 (default SLOTS); with SLOTS=7 -> out_count=7.
REQ-032 Flush: 3 entries queued, test_ending with simultaneous dct_valid -> 4 entries drained in order, flush_done=1 cycle after empty; later dct_valid -> drop_count+1, overflow stays 0.
REQ-033 Abort/reset: 5 entries queued, test_has_ended=1 together with test_ending -> DONE, fifo_level=0, aborted=1, out_valid=0; reset_n pulse mid-FLUSH -> all outputs 0, state RUN.
REQ-034 Timestamp (macro defined): writes at cycles 10 and 25 after reset -> out_timestamp values differ by 15.
